// File: rtl/axis_luma_convert_if.sv
// AXI4-Stream video bus: tdata carries PPC pixels of three CW-bit components.
// tuser marks start of frame, tlast marks end of line.
interface axis_luma_convert_if #(
    parameter int unsigned PPC = 1,
    parameter int unsigned CW  = 8
);
    logic [3*CW*PPC-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tuser;
    logic                tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_luma_convert.sv
// Three-stage pixel processor: bypass, weighted luma, invert or threshold per pixel.
// The mode is captured on each start-of-frame beat, so a frame never mixes modes.
module axis_luma_convert #(
    parameter int unsigned PPC = 1,
    parameter int unsigned CW  = 8,
    parameter int unsigned CF  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_luma_convert_if.slave    s_axis_video,
    axis_luma_convert_if.master   m_axis_video,
    input  logic [1:0]            cfg_mode,
    input  logic [CF:0]           cfg_coef_r,
    input  logic [CF:0]           cfg_coef_g,
    input  logic [CF:0]           cfg_coef_b,
    input  logic [CW-1:0]         cfg_thresh,
    output logic [15:0]           frame_count
);
    localparam int unsigned PW = CW + CF + 1;
    localparam int unsigned SW = CW + CF + 3;
    localparam int unsigned DW = 3 * CW * PPC;
    localparam logic [CW-1:0] MaxVal = '1;

    typedef enum logic [1:0] {ModeBypass, ModeGrey, ModeInvert, ModeThresh} mode_e;

    logic ce;
    logic s_acc;
    mode_e mode_q;
    mode_e beat_mode;

    logic          v1_q, v2_q;
    logic          user1_q, user2_q, last1_q, last2_q;
    mode_e         mode1_q, mode2_q;
    logic [CW-1:0] thr1_q, thr2_q;
    logic [DW-1:0] pix1_q, pix2_q;

    logic [DW-1:0] out_data_d;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q, out_user_q, out_last_q;

    assign ce = m_axis_video.tready | ~out_valid_q;
    assign s_axis_video.tready = ce;
    assign s_acc = s_axis_video.tvalid & ce;

    // A start-of-frame beat already uses the freshly requested mode.
    assign beat_mode = s_axis_video.tuser ? mode_e'(cfg_mode) : mode_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mode_q <= ModeBypass;
        end else if (s_acc && s_axis_video.tuser) begin
            mode_q <= mode_e'(cfg_mode);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            user1_q     <= 1'b0;
            user2_q     <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            mode1_q     <= ModeBypass;
            mode2_q     <= ModeBypass;
            thr1_q      <= '0;
            thr2_q      <= '0;
            pix1_q      <= '0;
            pix2_q      <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (ce) begin
            v1_q        <= s_acc;
            user1_q     <= s_axis_video.tuser & s_axis_video.tvalid;
            last1_q     <= s_axis_video.tlast & s_axis_video.tvalid;
            mode1_q     <= beat_mode;
            thr1_q      <= cfg_thresh;
            pix1_q      <= s_axis_video.tdata;
            v2_q        <= v1_q;
            user2_q     <= user1_q;
            last2_q     <= last1_q;
            mode2_q     <= mode1_q;
            thr2_q      <= thr1_q;
            pix2_q      <= pix1_q;
            out_valid_q <= v2_q;
            out_user_q  <= user2_q;
            out_last_q  <= last2_q;
            out_data_q  <= out_data_d;
        end
    end

    for (genvar p = 0; p < PPC; p++) begin : g_lane
        logic [CW-1:0]    in_r, in_b, in_g;
        logic [CW-1:0]    r2, b2, g2;
        logic [PW-1:0]    pr_q, pg_q, pb_q;
        logic [SW-1:0]    sum_q;
        logic [SW-1:0]    rounded;
        logic [SW-CF-1:0] y_full;
        logic [CW-1:0]    y;
        logic [CW-1:0]    t;
        logic [3*CW-1:0]  lane_d;

        assign in_r = s_axis_video.tdata[p*3*CW + 2*CW +: CW];
        assign in_b = s_axis_video.tdata[p*3*CW + CW +: CW];
        assign in_g = s_axis_video.tdata[p*3*CW +: CW];
        assign r2   = pix2_q[p*3*CW + 2*CW +: CW];
        assign b2   = pix2_q[p*3*CW + CW +: CW];
        assign g2   = pix2_q[p*3*CW +: CW];

        always_ff @(posedge aclk) begin
            if (ce) begin
                pr_q  <= PW'(cfg_coef_r) * PW'(in_r);
                pg_q  <= PW'(cfg_coef_g) * PW'(in_g);
                pb_q  <= PW'(cfg_coef_b) * PW'(in_b);
                sum_q <= SW'(pr_q) + SW'(pg_q) + SW'(pb_q);
            end
        end

        assign rounded = sum_q + SW'(2 ** (CF - 1));
        assign y_full  = rounded[SW-1:CF];
        assign y       = (|y_full[SW-CF-1:CW]) ? MaxVal : y_full[CW-1:0];
        assign t       = (y >= thr2_q) ? MaxVal : '0;

        always_comb begin
            lane_d = pix2_q[p*3*CW +: 3*CW];
            unique case (mode2_q)
                ModeBypass: lane_d = {r2, b2, g2};
                ModeGrey:   lane_d = {y, y, y};
                ModeInvert: lane_d = {MaxVal - r2, MaxVal - b2, MaxVal - g2};
                ModeThresh: lane_d = {t, t, t};
                default:    lane_d = {r2, b2, g2};
            endcase
        end

        assign out_data_d[p*3*CW +: 3*CW] = lane_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frame_count <= '0;
        end else if (out_valid_q && m_axis_video.tready && out_user_q) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign m_axis_video.tvalid = out_valid_q;
    assign m_axis_video.tdata  = out_data_q;
    assign m_axis_video.tuser  = out_user_q;
    assign m_axis_video.tlast  = out_last_q;
endmodule

// File: tb/tb_axis_luma_convert.sv
// Bench for axis_luma_convert: a PPC=1 and a PPC=4 instance checked against
// an arithmetic per-pixel model with a bench-side mode latch.
module tb_axis_luma_convert;
    logic       clk;
    logic       rstn;
    logic [1:0] cfg_mode;
    logic [8:0] coef_r, coef_g, coef_b;
    logic [7:0] thresh;
    logic [15:0] fc1, fc4;

    int vectors;
    int miscompares;
    logic [25:0] got[$];

    axis_luma_convert_if #(.PPC(1), .CW(8)) s1 ();
    axis_luma_convert_if #(.PPC(1), .CW(8)) m1 ();
    axis_luma_convert_if #(.PPC(4), .CW(8)) s4 ();
    axis_luma_convert_if #(.PPC(4), .CW(8)) m4 ();

    axis_luma_convert #(.PPC(1), .CW(8), .CF(8)) dut1 (
        .aclk(clk), .aresetn(rstn), .s_axis_video(s1), .m_axis_video(m1),
        .cfg_mode(cfg_mode), .cfg_coef_r(coef_r), .cfg_coef_g(coef_g), .cfg_coef_b(coef_b),
        .cfg_thresh(thresh), .frame_count(fc1)
    );

    axis_luma_convert #(.PPC(4), .CW(8), .CF(8)) dut4 (
        .aclk(clk), .aresetn(rstn), .s_axis_video(s4), .m_axis_video(m4),
        .cfg_mode(cfg_mode), .cfg_coef_r(coef_r), .cfg_coef_g(coef_g), .cfg_coef_b(coef_b),
        .cfg_thresh(thresh), .frame_count(fc4)
    );

    always #5 clk = ~clk;

    // Pixel is {R,B,G}; Y is the rounded weighted sum, saturated to 255.
    function automatic logic [23:0] model(input logic [1:0] mode, input logic [23:0] px,
                                          input int cr, input int cg, input int cb, input int th);
        int r, g, b, y;
        logic [7:0] y8, t8;
        r  = int'(px[23:16]);
        b  = int'(px[15:8]);
        g  = int'(px[7:0]);
        y  = (cr * r + cg * g + cb * b + 128) / 256;
        if (y > 255) y = 255;
        y8 = 8'(y);
        t8 = (y >= th) ? 8'hFF : 8'h00;
        case (mode)
            2'd0:    return px;
            2'd1:    return {y8, y8, y8};
            2'd2:    return ~px;
            default: return {t8, t8, t8};
        endcase
    endfunction

    task automatic drive1(input logic [23:0] d, input logic u, input logic l);
        logic ok;
        ok = 1'b0;
        s1.tdata  = d;
        s1.tuser  = u;
        s1.tlast  = l;
        s1.tvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1 ok = s1.tready;
            @(negedge clk);
            if (ok) break;
        end
        s1.tvalid = 1'b0;
        s1.tuser  = 1'b0;
        s1.tlast  = 1'b0;
    endtask

    task automatic collect1(input int n);
        got.delete();
        for (int c = 0; c < 40 && got.size() < n; c++) begin
            @(negedge clk);
            #1;
            if (m1.tvalid && m1.tready) got.push_back({m1.tuser, m1.tlast, m1.tdata});
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (m1.tvalid !== 1'b0 || m1.tuser !== 1'b0 || m1.tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_side: got v/u/l %b%b%b expected 000", m1.tvalid, m1.tuser, m1.tlast);
        end
        vectors++;
        if (m1.tdata !== 24'h0 || fc1 !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_data: got tdata %h fc %0d expected 0 0", m1.tdata, fc1);
        end
        vectors++;
        if (m4.tvalid !== 1'b0 || m4.tdata !== 96'h0 || fc4 !== 16'd0 || s1.tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ppc4: got v %b data %h fc %0d s_rdy %b expected 0 0 0 1",
                     m4.tvalid, m4.tdata, fc4, s1.tready);
        end
        rstn = 1'b1;
    endtask

    task automatic test_grey_latency();
        @(negedge clk);
        cfg_mode = 2'd1;
        drive1(24'h64C832, 1'b1, 1'b1);
        #1;
        vectors++;
        if (m1.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_c1: got tvalid %b expected 0", m1.tvalid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m1.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_c2: got tvalid %b expected 0", m1.tvalid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({m1.tvalid, m1.tuser, m1.tlast, m1.tdata} !== {3'b111, 24'h525252}) begin
            miscompares++;
            $display("FAIL latency_c3: got v/u/l %b%b%b data %h expected 111 525252",
                     m1.tvalid, m1.tuser, m1.tlast, m1.tdata);
        end
        @(negedge clk);
    endtask

    task automatic test_grey_saturate();
        logic [25:0] exp[2];
        exp[0] = {2'b10, model(2'd1, 24'hFFFFFF, 77, 150, 29, 0)};
        exp[1] = {2'b01, 24'hFFFFFF};
        @(negedge clk);
        cfg_mode = 2'd1;
        fork
            begin
                drive1(24'hFFFFFF, 1'b1, 1'b0);
                coef_r = 9'd511; coef_g = 9'd511; coef_b = 9'd511;
                drive1(24'hFFFFFF, 1'b0, 1'b1);
                coef_r = 9'd77; coef_g = 9'd150; coef_b = 9'd29;
            end
            collect1(2);
        join
        vectors++;
        if (got.size() != 2) begin
            miscompares++;
            $display("FAIL sat_count: got %0d beats expected 2", got.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL sat_beat%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [23:0] px[4];
        logic [25:0] exp[4];
        px[0] = 24'($urandom);
        px[1] = 24'($urandom);
        px[2] = 24'($urandom);
        px[3] = 24'h102030;
        for (int i = 0; i < 3; i++) exp[i] = {i == 0, i == 2, model(2'd1, px[i], 77, 150, 29, 0)};
        exp[3] = {2'b11, 24'hEFDFCF};
        apply_reset();
        cfg_mode = 2'd1;
        fork
            begin
                drive1(px[0], 1'b1, 1'b0);
                cfg_mode = 2'd2;
                drive1(px[1], 1'b0, 1'b0);
                drive1(px[2], 1'b0, 1'b1);
                drive1(px[3], 1'b1, 1'b1);
            end
            collect1(4);
        join
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL mode_count: got %0d beats expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL mode_beat%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (fc1 !== 16'd2) begin
            miscompares++;
            $display("FAIL frame_count: got %0d expected 2", fc1);
        end
    endtask

    task automatic test_threshold();
        @(negedge clk);
        cfg_mode = 2'd3;
        fork
            begin
                thresh = 8'd82;
                drive1(24'h64C832, 1'b1, 1'b0);
                thresh = 8'd83;
                drive1(24'h64C832, 1'b0, 1'b1);
            end
            collect1(2);
        join
        vectors++;
        if (got.size() != 2 || got[0][23:0] !== 24'hFFFFFF || got[1][23:0] !== 24'h000000) begin
            miscompares++;
            $display("FAIL threshold: got %0d beats %h %h expected ffffff 000000",
                     got.size(), got.size() > 0 ? got[0] : 26'h0, got.size() > 1 ? got[1] : 26'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] exp_q[$];
        logic [25:0] held_val;
        logic [25:0] want;
        logic [1:0]  exp_mode;
        logic        held;
        int sent, cr, cg, cb, th;
        sent = 0;
        held = 1'b0;
        held_val = '0;
        exp_mode = 2'd0;
        coef_r = 9'($urandom_range(0, 511));
        coef_g = 9'($urandom_range(0, 511));
        coef_b = 9'($urandom_range(0, 511));
        thresh = 8'($urandom);
        cr = int'(coef_r); cg = int'(coef_g); cb = int'(coef_b); th = int'(thresh);
        for (int c = 0; c < 2000 && (sent < 20 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            if (held) begin
                vectors++;
                if (m1.tvalid !== 1'b1 || {m1.tuser, m1.tlast, m1.tdata} !== held_val) begin
                    miscompares++;
                    $display("FAIL bp_hold: got v %b %h expected 1 %h", m1.tvalid,
                             {m1.tuser, m1.tlast, m1.tdata}, held_val);
                end
            end
            m1.tready = 1'($urandom_range(0, 1));
            cfg_mode  = 2'($urandom_range(0, 3));
            s1.tvalid = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            s1.tdata  = 24'($urandom);
            s1.tuser  = (sent == 0);
            s1.tlast  = 1'($urandom_range(0, 1));
            #1;
            if (m1.tvalid && !m1.tready) begin
                vectors++;
                if (s1.tready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_sready: got %b expected 0", s1.tready);
                end
            end
            if (m1.tvalid && m1.tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: got %h expected no beat", {m1.tuser, m1.tlast, m1.tdata});
                end else begin
                    want = exp_q.pop_front();
                    if ({m1.tuser, m1.tlast, m1.tdata} !== want) begin
                        miscompares++;
                        $display("FAIL bp_data: got %h expected %h", {m1.tuser, m1.tlast, m1.tdata}, want);
                    end
                end
            end
            if (s1.tvalid && s1.tready) begin
                if (s1.tuser) exp_mode = cfg_mode;
                exp_q.push_back({s1.tuser, s1.tlast, model(exp_mode, s1.tdata, cr, cg, cb, th)});
                sent++;
            end
            held = m1.tvalid && !m1.tready;
            held_val = {m1.tuser, m1.tlast, m1.tdata};
        end
        vectors++;
        if (sent != 20 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: got sent %0d pending %0d expected 20 0", sent, exp_q.size());
        end
        @(negedge clk);
        s1.tvalid = 1'b0;
        s1.tuser  = 1'b0;
        s1.tlast  = 1'b0;
        m1.tready = 1'b1;
        coef_r = 9'd77; coef_g = 9'd150; coef_b = 9'd29;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ppc4();
        logic [95:0] beats[4];
        int got4;
        got4 = 0;
        for (int b = 0; b < 4; b++) beats[b] = {32'($urandom), 32'($urandom), 32'($urandom)};
        @(negedge clk);
        cfg_mode = 2'd1;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    s4.tdata  = beats[b];
                    s4.tuser  = (b == 0);
                    s4.tlast  = (b == 3);
                    s4.tvalid = 1'b1;
                    @(negedge clk);
                end
                s4.tvalid = 1'b0;
                s4.tuser  = 1'b0;
                s4.tlast  = 1'b0;
            end
            begin
                for (int c = 0; c < 20 && got4 < 4; c++) begin
                    @(negedge clk);
                    #1;
                    if (m4.tvalid) begin
                        for (int l = 0; l < 4; l++) begin
                            vectors++;
                            if (m4.tdata[l*24 +: 24] !== model(2'd1, beats[got4][l*24 +: 24], 77, 150, 29, 0)) begin
                                miscompares++;
                                $display("FAIL ppc4_b%0d_l%0d: got %h expected %h", got4, l,
                                         m4.tdata[l*24 +: 24], model(2'd1, beats[got4][l*24 +: 24], 77, 150, 29, 0));
                            end
                        end
                        vectors++;
                        if (m4.tlast !== (got4 == 3) || m4.tuser !== (got4 == 0)) begin
                            miscompares++;
                            $display("FAIL ppc4_side%0d: got u/l %b%b expected %b%b", got4,
                                     m4.tuser, m4.tlast, got4 == 0, got4 == 3);
                        end
                        got4++;
                    end
                end
            end
        join
        vectors++;
        if (got4 != 4) begin
            miscompares++;
            $display("FAIL ppc4_count: got %0d beats expected 4", got4);
        end
    endtask

    task automatic test_reset_inflight();
        int stale;
        stale = 0;
        @(negedge clk);
        cfg_mode = 2'd2;
        drive1(24'($urandom), 1'b1, 1'b0);
        drive1(24'($urandom), 1'b0, 1'b0);
        drive1(24'($urandom), 1'b0, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (m1.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flight: got tvalid %b expected 0", m1.tvalid);
        end
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m1.tvalid) stale++;
        end
        vectors++;
        if (stale != 0 || fc1 !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_stale: got %0d stale beats fc %0d expected 0 0", stale, fc1);
        end
    endtask

    initial begin
        clk = 1'b0;
        rstn = 1'b0;
        vectors = 0;
        miscompares = 0;
        cfg_mode = 2'd0;
        coef_r = 9'd77;
        coef_g = 9'd150;
        coef_b = 9'd29;
        thresh = 8'd0;
        s1.tdata = '0; s1.tvalid = 1'b0; s1.tuser = 1'b0; s1.tlast = 1'b0;
        s4.tdata = '0; s4.tvalid = 1'b0; s4.tuser = 1'b0; s4.tlast = 1'b0;
        m1.tready = 1'b1;
        m4.tready = 1'b1;
        test_reset();
        test_grey_latency();
        test_grey_saturate();
        test_mode_switch();
        test_threshold();
        test_backpressure();
        test_ppc4();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
